// File: rtl/ledpanel_pkg.sv
// Shared types for the LED panel write path: panel geometry, pixel record and
// scheduler FSM states.
package ledpanel_pkg;

  localparam int PANEL_COORD_W = 5;
  localparam int PANEL_RGB_W   = 24;

  typedef struct packed {
    logic [PANEL_COORD_W-1:0] x;
    logic [PANEL_COORD_W-1:0] y;
    logic [PANEL_RGB_W-1:0]   rgb;
  } pixel_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } sched_state_e;

endpackage

// File: rtl/ledpanel_wr_sched_if.sv
// CPU pixel port, fill command port and panel write port of the write scheduler.
interface ledpanel_wr_sched_if #(
    parameter int COORD_W = ledpanel_pkg::PANEL_COORD_W
);
    import ledpanel_pkg::*;

    logic                   cpu_valid;
    logic                   cpu_ready;
    logic [COORD_W-1:0]     cpu_x;
    logic [COORD_W-1:0]     cpu_y;
    logic [PANEL_RGB_W-1:0] cpu_rgb;

    logic                   fill_start;
    logic [COORD_W-1:0]     fill_x0;
    logic [COORD_W-1:0]     fill_y0;
    logic [COORD_W-1:0]     fill_x1;
    logic [COORD_W-1:0]     fill_y1;
    logic [PANEL_RGB_W-1:0] fill_rgb;
    logic                   fill_abort;
    logic                   fill_busy;
    logic                   fill_done;
    logic                   fill_err;

    logic                   wr_enable;
    logic [COORD_W-1:0]     wr_addr_x;
    logic [COORD_W-1:0]     wr_addr_y;
    logic [PANEL_RGB_W-1:0] wr_rgb_data;

    modport master (
        output cpu_valid, cpu_x, cpu_y, cpu_rgb,
        output fill_start, fill_x0, fill_y0, fill_x1, fill_y1, fill_rgb, fill_abort,
        input  cpu_ready, fill_busy, fill_done, fill_err,
        input  wr_enable, wr_addr_x, wr_addr_y, wr_rgb_data
    );

    modport slave (
        input  cpu_valid, cpu_x, cpu_y, cpu_rgb,
        input  fill_start, fill_x0, fill_y0, fill_x1, fill_y1, fill_rgb, fill_abort,
        output cpu_ready, fill_busy, fill_done, fill_err,
        output wr_enable, wr_addr_x, wr_addr_y, wr_rgb_data
    );

endinterface

// File: rtl/ledpanel_rect_walker.sv
// Raster cursor over an inclusive rectangle; advances one pixel per step.
module ledpanel_rect_walker #(
    parameter int COORD_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic               abort,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    output logic [COORD_W-1:0] cur_x,
    output logic [COORD_W-1:0] cur_y,
    output logic               last
);

    logic [COORD_W-1:0] bx0, bx1, by1;
    logic [COORD_W:0]   nx;

    // One extra bit so x1 = max column does not wrap before the compare.
    assign nx   = {1'b0, cur_x} + 1'b1;
    assign last = (cur_x == bx1) && (cur_y == by1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bx0   <= '0;
            bx1   <= '0;
            by1   <= '0;
            cur_x <= '0;
            cur_y <= '0;
        end else if (load) begin
            bx0   <= x0;
            bx1   <= x1;
            by1   <= y1;
            cur_x <= x0;
            cur_y <= y0;
        end else if (abort) begin
            cur_x <= '0;
            cur_y <= '0;
        end else if (step) begin
            if (nx <= {1'b0, bx1}) begin
                cur_x <= nx[COORD_W-1:0];
            end else begin
                cur_x <= bx0;
                cur_y <= cur_y + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ledpanel_wr_sched.sv
// Shares the panel pixel write port between the CPU and the rectangle-fill
// engine with a bounded fill burst; panel outputs are registered.
module ledpanel_wr_sched
    import ledpanel_pkg::*;
#(
    parameter int FILL_BURST = 4,
    parameter int COORD_W    = PANEL_COORD_W
) (
    input logic                 clk,
    input logic                 reset,
    ledpanel_wr_sched_if.slave  bus
);

    localparam int BW = $clog2(FILL_BURST + 2);
    localparam logic [BW-1:0] BURST_MAX = BW'(FILL_BURST);

    sched_state_e           state, state_n;
    logic [BW-1:0]          burst_cnt;
    logic [PANEL_RGB_W-1:0] fill_rgb_q;
    logic [COORD_W-1:0]     cur_x, cur_y;
    logic                   last, load, done_set, err_set;
    logic                   fill_req, fill_grant, cpu_grant;

    assign fill_req      = (state == ST_FILL);
    assign bus.cpu_ready = !fill_req || (burst_cnt >= BURST_MAX);
    assign cpu_grant     = bus.cpu_valid && bus.cpu_ready;
    assign fill_grant    = fill_req && !cpu_grant;
    assign bus.fill_busy = fill_req;

    ledpanel_rect_walker #(.COORD_W(COORD_W)) u_walker (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .step  (fill_grant),
        .abort (fill_req && bus.fill_abort),
        .x0    (bus.fill_x0),
        .y0    (bus.fill_y0),
        .x1    (bus.fill_x1),
        .y1    (bus.fill_y1),
        .cur_x (cur_x),
        .cur_y (cur_y),
        .last  (last)
    );

    always_comb begin
        state_n  = state;
        load     = 1'b0;
        done_set = 1'b0;
        err_set  = 1'b0;
        unique case (state)
            ST_IDLE: if (bus.fill_start) begin
                if (bus.fill_x0 <= bus.fill_x1 && bus.fill_y0 <= bus.fill_y1) begin
                    load    = 1'b1;
                    state_n = ST_FILL;
                end else begin
                    err_set = 1'b1;
                end
            end
            ST_FILL: if (bus.fill_abort || (fill_grant && last)) begin
                state_n  = ST_IDLE;
                done_set = 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            burst_cnt     <= '0;
            fill_rgb_q    <= '0;
            bus.fill_done <= 1'b0;
            bus.fill_err  <= 1'b0;
        end else begin
            state         <= state_n;
            bus.fill_done <= done_set;
            bus.fill_err  <= err_set;
            if (load) fill_rgb_q <= bus.fill_rgb;
            // Burst credit only accrues while a CPU write is actually waiting.
            if (!bus.cpu_valid || cpu_grant)
                burst_cnt <= '0;
            else if (fill_grant && burst_cnt < BURST_MAX)
                burst_cnt <= burst_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.wr_enable   <= 1'b0;
            bus.wr_addr_x   <= '0;
            bus.wr_addr_y   <= '0;
            bus.wr_rgb_data <= '0;
        end else begin
            bus.wr_enable <= cpu_grant || fill_grant;
            if (cpu_grant) begin
                bus.wr_addr_x   <= bus.cpu_x;
                bus.wr_addr_y   <= bus.cpu_y;
                bus.wr_rgb_data <= bus.cpu_rgb;
            end else if (fill_grant) begin
                bus.wr_addr_x   <= cur_x;
                bus.wr_addr_y   <= cur_y;
                bus.wr_rgb_data <= fill_rgb_q;
            end
        end
    end

endmodule

// File: tb/tb_ledpanel_wr_sched.sv
// Directed bench for ledpanel_wr_sched: CPU path, fills, arbitration, errors,
// abort and reset. Instance b runs with CPU strict priority.
module tb_ledpanel_wr_sched;
    import ledpanel_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ledpanel_wr_sched_if #(.COORD_W(5)) bus_a ();
    ledpanel_wr_sched_if #(.COORD_W(5)) bus_b ();

    ledpanel_wr_sched #(.FILL_BURST(4), .COORD_W(5)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    ledpanel_wr_sched #(.FILL_BURST(0), .COORD_W(5)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    localparam logic [23:0] CPU_RGB = 24'hABCDEF;

    pixel_t wa[$];
    int     wa_cyc[$];
    int     busy_a = 0, done_a = 0, err_a = 0;
    int     wb_cpu = 0, wb_fill = 0, done_b = 0;

    always @(negedge clk) begin
        if (bus_a.wr_enable) begin
            wa.push_back('{x: bus_a.wr_addr_x, y: bus_a.wr_addr_y, rgb: bus_a.wr_rgb_data});
            wa_cyc.push_back(cyc);
        end
        if (bus_a.fill_busy) busy_a++;
        if (bus_a.fill_done) done_a++;
        if (bus_a.fill_err)  err_a++;
        if (bus_b.wr_enable) begin
            if (bus_b.wr_rgb_data == CPU_RGB) wb_cpu++;
            else wb_fill++;
        end
        if (bus_b.fill_done) done_b++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_a();
        wa.delete();
        wa_cyc.delete();
        busy_a = 0;
    endtask

    task automatic start_a(input int x0, input int y0, input int x1, input int y1,
                           input logic [23:0] rgb);
        bus_a.fill_x0 = 5'(x0); bus_a.fill_y0 = 5'(y0);
        bus_a.fill_x1 = 5'(x1); bus_a.fill_y1 = 5'(y1);
        bus_a.fill_rgb = rgb;
        bus_a.fill_start = 1'b1;
    endtask

    task automatic wait_done_a(input string tag, input int d0, input int max);
        int n = 0;
        while (done_a == d0 && n < max) begin
            tick();
            n++;
        end
        chk(tag, 64'(done_a != d0), 64'd1);
    endtask

    // Reference raster order over the inclusive rectangle, starting at wa[off].
    task automatic chk_raster(input string tag, input int x0, input int y0, input int x1,
                              input int y1, input logic [23:0] rgb, input int off);
        int errs = 0;
        int k = off;
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++) begin
                if (k >= wa.size()) errs++;
                else if (wa[k] != '{x: 5'(x), y: 5'(y), rgb: rgb}) errs++;
                k++;
            end
        chk(tag, 64'(errs), 64'd0);
    endtask

    initial begin
        int c0, d0, e0, n0, run, max_run, errs, ncpu, rdy;

        bus_a.cpu_valid = 0; bus_a.cpu_x = 0; bus_a.cpu_y = 0; bus_a.cpu_rgb = 0;
        bus_a.fill_start = 0; bus_a.fill_x0 = 0; bus_a.fill_y0 = 0; bus_a.fill_x1 = 0;
        bus_a.fill_y1 = 0; bus_a.fill_rgb = 0; bus_a.fill_abort = 0;
        bus_b.cpu_valid = 0; bus_b.cpu_x = 0; bus_b.cpu_y = 0; bus_b.cpu_rgb = 0;
        bus_b.fill_start = 0; bus_b.fill_x0 = 0; bus_b.fill_y0 = 0; bus_b.fill_x1 = 0;
        bus_b.fill_y1 = 0; bus_b.fill_rgb = 0; bus_b.fill_abort = 0;

        repeat (3) tick();
        chk("rst_outs", {bus_a.wr_enable, bus_a.fill_busy, bus_a.fill_done, bus_a.fill_err}, 0);
        chk("rst_data", {bus_a.wr_addr_x, bus_a.wr_addr_y, bus_a.wr_rgb_data}, 0);
        reset = 1'b0;
        tick();

        // CPU back-to-back writes
        clr_a();
        c0 = cyc;
        bus_a.cpu_valid = 1; bus_a.cpu_x = 3; bus_a.cpu_y = 5; bus_a.cpu_rgb = 24'hFF0000;
        chk("t1_rdy0", bus_a.cpu_ready, 1);
        tick();
        bus_a.cpu_x = 31; bus_a.cpu_y = 31; bus_a.cpu_rgb = 24'h00FF00;
        chk("t1_rdy1", bus_a.cpu_ready, 1);
        tick();
        bus_a.cpu_valid = 0;
        repeat (2) tick();
        chk("t1_cnt", wa.size(), 2);
        if (wa.size() == 2) begin
            chk("t1_px0", wa[0], {5'd3, 5'd5, 24'hFF0000});
            chk("t1_px1", wa[1], {5'd31, 5'd31, 24'h00FF00});
            chk("t1_cyc0", wa_cyc[0], c0 + 1);
            chk("t1_cyc1", wa_cyc[1], c0 + 2);
        end

        // Small rectangle fill
        clr_a();
        d0 = done_a;
        start_a(2, 1, 4, 2, 24'h123456);
        tick();
        bus_a.fill_start = 0;
        wait_done_a("t2_done_to", d0, 40);
        repeat (3) tick();
        chk("t2_cnt", wa.size(), 6);
        chk_raster("t2_order", 2, 1, 4, 2, 24'h123456, 0);
        chk("t2_done", done_a - d0, 1);
        chk("t2_busy", busy_a, 6);

        // Full-panel fill
        clr_a();
        d0 = done_a;
        start_a(0, 0, 31, 31, 24'h0000AA);
        tick();
        bus_a.fill_start = 0;
        wait_done_a("t3_done_to", d0, 1100);
        repeat (3) tick();
        chk("t3_cnt", wa.size(), 1024);
        chk_raster("t3_order", 0, 0, 31, 31, 24'h0000AA, 0);
        if (wa.size() > 0) chk("t3_last", wa[wa.size()-1], {5'd31, 5'd31, 24'h0000AA});

        // Weighted arbitration: CPU held valid through a 32-pixel fill
        clr_a();
        d0 = done_a;
        bus_a.cpu_valid = 1; bus_a.cpu_x = 7; bus_a.cpu_y = 7; bus_a.cpu_rgb = CPU_RGB;
        start_a(0, 0, 31, 0, 24'h000011);
        run = 0; max_run = 0;
        for (int i = 0; i < 41; i++) begin
            if (!bus_a.cpu_ready) run++;
            else run = 0;
            if (run > max_run) max_run = run;
            tick();
            bus_a.fill_start = 0;
        end
        bus_a.cpu_valid = 0;
        repeat (3) tick();
        chk("t4_cnt", wa.size(), 41);
        errs = 0; ncpu = 0;
        foreach (wa[i]) begin
            if ((wa[i].rgb == CPU_RGB) != (i % 5 == 0)) errs++;
            if (wa[i].rgb == CPU_RGB) ncpu++;
        end
        chk("t4_pattern", errs, 0);
        chk("t4_ncpu", ncpu, 9);
        chk("t4_maxwait", max_run, 4);
        chk("t4_done", done_a - d0, 1);

        // CPU strict priority (FILL_BURST = 0)
        bus_b.cpu_valid = 1; bus_b.cpu_x = 1; bus_b.cpu_y = 2; bus_b.cpu_rgb = CPU_RGB;
        bus_b.fill_x0 = 0; bus_b.fill_y0 = 0; bus_b.fill_x1 = 31; bus_b.fill_y1 = 0;
        bus_b.fill_rgb = 24'h000022; bus_b.fill_start = 1;
        rdy = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus_b.cpu_ready) rdy++;
            tick();
            bus_b.fill_start = 0;
        end
        bus_b.cpu_valid = 0;
        chk("t4b_ready", rdy, 10);
        chk("t4b_nofill", wb_fill, 0);
        n0 = 0;
        while (done_b == 0 && n0 < 60) begin
            tick();
            n0++;
        end
        repeat (2) tick();
        chk("t4b_cpu", wb_cpu, 10);
        chk("t4b_fill", wb_fill, 32);
        chk("t4b_done", done_b, 1);

        // Rejected start
        clr_a();
        e0 = err_a;
        start_a(10, 0, 9, 0, 24'h777777);
        tick();
        bus_a.fill_start = 0;
        repeat (3) tick();
        chk("t5_err", err_a - e0, 1);
        chk("t5_nowr", wa.size(), 0);
        chk("t5_busy", busy_a, 0);

        // Abort during the third pixel of a 16-pixel fill
        clr_a();
        d0 = done_a;
        start_a(0, 0, 15, 0, 24'h0F0F0F);
        tick();
        bus_a.fill_start = 0;
        tick();
        tick();
        bus_a.fill_abort = 1;
        tick();
        bus_a.fill_abort = 0;
        repeat (3) tick();
        chk("t6_cnt", wa.size(), 3);
        chk_raster("t6_order", 0, 0, 2, 0, 24'h0F0F0F, 0);
        chk("t6_done", done_a - d0, 1);
        chk("t6_busy", bus_a.fill_busy, 0);
        d0 = done_a;
        bus_a.fill_abort = 1;
        tick();
        bus_a.fill_abort = 0;
        repeat (2) tick();
        chk("t6_idle_abort", done_a - d0, 0);

        // Reset in the middle of a fill
        clr_a();
        d0 = done_a;
        start_a(0, 0, 15, 0, 24'h0F0F0F);
        tick();
        bus_a.fill_start = 0;
        repeat (3) tick();
        reset = 1'b1;
        #1;
        chk("t6r_outs", {bus_a.wr_enable, bus_a.fill_busy, bus_a.fill_done, bus_a.fill_err}, 0);
        chk("t6r_data", {bus_a.wr_addr_x, bus_a.wr_addr_y, bus_a.wr_rgb_data}, 0);
        repeat (2) tick();
        reset = 1'b0;
        n0 = wa.size();
        repeat (20) tick();
        chk("t6r_nodone", done_a - d0, 0);
        chk("t6r_nowr", wa.size() - n0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
